// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencer: state encoding, register-zero constant
// and the default drain length.
package pipe_pkg;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned REG_W   = 5;

    localparam logic [STATE_W-1:0] ST_RUN    = 3'd0;
    localparam logic [STATE_W-1:0] ST_PAUSE  = 3'd1;
    localparam logic [STATE_W-1:0] ST_STEP   = 3'd2;
    localparam logic [STATE_W-1:0] ST_DRAIN  = 3'd3;
    localparam logic [STATE_W-1:0] ST_HALTED = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        RUN    = ST_RUN,
        PAUSE  = ST_PAUSE,
        STEP   = ST_STEP,
        DRAIN  = ST_DRAIN,
        HALTED = ST_HALTED
    } pipeState_t;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
    localparam int unsigned DEFAULT_DRAIN_CYCLES = 3;
endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detector: the load in EX writes a register the ID instruction reads.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic             ex_memtoreg,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    output logic             load_use
);
    logic rsHit;
    logic rtHit;

    assign rsHit    = id_uses_rs && (id_rs == ex_rt);
    assign rtHit    = id_uses_rt && (id_rt == ex_rt);
    // Writes to $zero are discarded, so they never create a dependency.
    assign load_use = ex_memtoreg && (ex_rt != REG_ZERO) && (rsHit || rtHit);
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: load-use stall, branch flush, HALT drain, debug pause/step gating
// and saturating cycle/stall counters.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES  = DEFAULT_DRAIN_CYCLES,
    parameter int unsigned CNT_W         = 32,
    parameter bit          START_RUNNING = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_halt,
    input  logic             branch_taken,
    input  logic             ex_memtoreg,
    input  logic [4:0]       ex_rt,
    input  logic             dbg_pause,
    input  logic             dbg_step,
    output logic             pipe_en,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_clear,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] stall_count
);
    localparam int unsigned       DRAIN_W     = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
    localparam pipeState_t        RESET_STATE = START_RUNNING ? RUN : PAUSE;

    pipeState_t         state;
    logic [DRAIN_W-1:0] drainCnt;
    logic               loadUse;
    logic               haltGo;

    hazard_detect uHazard (
        .ex_memtoreg(ex_memtoreg),
        .ex_rt      (ex_rt),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .load_use   (loadUse)
    );

    assign pipe_en = (state == RUN) || (state == STEP) || (state == DRAIN);
    assign halted  = (state == HALTED);
    // A stalled HALT has stale operands and is re-evaluated next cycle.
    assign haltGo  = id_halt && !loadUse;

    // Zero-latency pipeline-register enables and clears.
    always_comb begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ifid_flush = 1'b0;
        idex_clear = 1'b0;
        if (state == DRAIN) begin
            ifid_write = 1'b1;
            ifid_flush = 1'b1;
            idex_clear = 1'b1;
        end else if (pipe_en) begin
            if (loadUse) begin
                idex_clear = 1'b1;
            end else if (id_halt) begin
                ifid_write = 1'b1;
                ifid_flush = 1'b1;
            end else begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
                ifid_flush = branch_taken;
            end
        end
    end

    // Sequencer state, drain counter and saturating counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RESET_STATE;
            drainCnt    <= '0;
            cycle_count <= '0;
            stall_count <= '0;
        end else begin
            if (pipe_en && (cycle_count != CNT_MAX)) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
            if (pipe_en && loadUse && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            case (state)
                RUN: begin
                    if (haltGo) begin
                        state    <= DRAIN;
                        drainCnt <= DRAIN_LOAD;
                    end else if (dbg_pause) begin
                        state <= PAUSE;
                    end
                end
                STEP: begin
                    if (haltGo) begin
                        state    <= DRAIN;
                        drainCnt <= DRAIN_LOAD;
                    end else begin
                        state <= PAUSE;
                    end
                end
                PAUSE: begin
                    if (dbg_step) begin
                        state <= STEP;
                    end else if (!dbg_pause) begin
                        state <= RUN;
                    end
                end
                DRAIN: begin
                    if (drainCnt == '0) begin
                        state <= HALTED;
                    end else begin
                        drainCnt <= drainCnt - DRAIN_W'(1);
                    end
                end
                HALTED: state <= HALTED;
                default: state <= RESET_STATE;
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: three instances (default, 4-bit counters, start paused) checked
// against a mode/queue-level reference model, plus vector tables and directed sequences.
module tb_pipeline_ctrl;
    localparam int NDUT   = 3;
    localparam int DRAIN  = 3;
    localparam int M_RUN = 0, M_PAUSE = 1, M_STEP = 2, M_DRAIN = 3, M_HALTED = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rs, id_uses_rt, id_halt, branch_taken, ex_memtoreg;
    logic       dbg_pause, dbg_step;

    logic        pe[NDUT], pw[NDUT], iw[NDUT], fl[NDUT], cl[NDUT], hl[NDUT];
    logic [31:0] cc0, sc0, cc2, sc2;
    logic [3:0]  cc1, sc1;

    int tests = 0;
    int fails = 0;

    int     mMode[NDUT];
    int     mDrainLeft[NDUT];
    longint mCyc[NDUT];
    longint mStl[NDUT];
    int     mStart[NDUT] = '{1, 1, 0};
    longint mMax[NDUT]   = '{64'hFFFF_FFFF, 64'd15, 64'hFFFF_FFFF};

    always #5 clk = ~clk;

    pipeline_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(32), .START_RUNNING(1'b1)) dut0 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .id_halt(id_halt), .branch_taken(branch_taken),
        .ex_memtoreg(ex_memtoreg), .ex_rt(ex_rt), .dbg_pause(dbg_pause), .dbg_step(dbg_step),
        .pipe_en(pe[0]), .pc_write(pw[0]), .ifid_write(iw[0]), .ifid_flush(fl[0]),
        .idex_clear(cl[0]), .halted(hl[0]), .cycle_count(cc0), .stall_count(sc0));

    pipeline_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(4), .START_RUNNING(1'b1)) dut1 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .id_halt(id_halt), .branch_taken(branch_taken),
        .ex_memtoreg(ex_memtoreg), .ex_rt(ex_rt), .dbg_pause(dbg_pause), .dbg_step(dbg_step),
        .pipe_en(pe[1]), .pc_write(pw[1]), .ifid_write(iw[1]), .ifid_flush(fl[1]),
        .idex_clear(cl[1]), .halted(hl[1]), .cycle_count(cc1), .stall_count(sc1));

    pipeline_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(32), .START_RUNNING(1'b0)) dut2 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .id_halt(id_halt), .branch_taken(branch_taken),
        .ex_memtoreg(ex_memtoreg), .ex_rt(ex_rt), .dbg_pause(dbg_pause), .dbg_step(dbg_step),
        .pipe_en(pe[2]), .pc_write(pw[2]), .ifid_write(iw[2]), .ifid_flush(fl[2]),
        .idex_clear(cl[2]), .halted(hl[2]), .cycle_count(cc2), .stall_count(sc2));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ccOf(input int k);
        case (k)
            0:       return 64'(cc0);
            1:       return 64'(cc1);
            default: return 64'(cc2);
        endcase
    endfunction

    function automatic logic [63:0] scOf(input int k);
        case (k)
            0:       return 64'(sc0);
            1:       return 64'(sc1);
            default: return 64'(sc2);
        endcase
    endfunction

    function automatic bit modelLoadUse();
        bit hit;
        hit = (id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt);
        return ex_memtoreg && (ex_rt != 5'd0) && hit;
    endfunction

    function automatic bit modelEnabled(input int k);
        return mMode[k] == M_RUN || mMode[k] == M_STEP || mMode[k] == M_DRAIN;
    endfunction

    // Expected {pc_write, ifid_write, ifid_flush, idex_clear} from the model's view.
    function automatic logic [3:0] modelCtl(input int k);
        if (!modelEnabled(k))    return 4'b0000;
        if (mMode[k] == M_DRAIN) return 4'b0111;
        if (modelLoadUse())      return 4'b0001;
        if (id_halt)             return 4'b0110;
        if (branch_taken)        return 4'b1110;
        return 4'b1100;
    endfunction

    // Compare every instance against the model mid-cycle, while inputs are stable.
    task automatic evalNeg();
        logic [3:0] e;
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            e = modelCtl(k);
            check($sformatf("dut%0d pipe_en", k),     64'(pe[k]), 64'(modelEnabled(k)));
            check($sformatf("dut%0d pc_write", k),    64'(pw[k]), 64'(e[3]));
            check($sformatf("dut%0d ifid_write", k),  64'(iw[k]), 64'(e[2]));
            check($sformatf("dut%0d ifid_flush", k),  64'(fl[k]), 64'(e[1]));
            check($sformatf("dut%0d idex_clear", k),  64'(cl[k]), 64'(e[0]));
            check($sformatf("dut%0d halted", k),      64'(hl[k]), 64'(mMode[k] == M_HALTED));
            check($sformatf("dut%0d cycle_count", k), ccOf(k),   64'(mCyc[k]));
            check($sformatf("dut%0d stall_count", k), scOf(k),   64'(mStl[k]));
        end
    endtask

    task automatic modelReset(input int k);
        mMode[k]      = mStart[k] ? M_RUN : M_PAUSE;
        mDrainLeft[k] = 0;
        mCyc[k]       = 0;
        mStl[k]       = 0;
    endtask

    // Advance the model across the rising edge using the inputs that were applied.
    task automatic clockModel();
        bit lu;
        bit en;
        @(posedge clk);
        lu = modelLoadUse();
        for (int k = 0; k < NDUT; k++) begin
            en = modelEnabled(k);
            if (reset) begin
                modelReset(k);
            end else begin
                if (en && mCyc[k] < mMax[k]) mCyc[k]++;
                if (en && lu && mStl[k] < mMax[k]) mStl[k]++;
                case (mMode[k])
                    M_RUN, M_STEP: begin
                        if (id_halt && !lu) begin
                            mMode[k]      = M_DRAIN;
                            mDrainLeft[k] = DRAIN;
                        end else if (mMode[k] == M_STEP || dbg_pause) begin
                            mMode[k] = M_PAUSE;
                        end
                    end
                    M_PAUSE: begin
                        if (dbg_step)        mMode[k] = M_STEP;
                        else if (!dbg_pause) mMode[k] = M_RUN;
                    end
                    M_DRAIN: begin
                        mDrainLeft[k]--;
                        if (mDrainLeft[k] == 0) mMode[k] = M_HALTED;
                    end
                    default: mMode[k] = M_HALTED;
                endcase
            end
        end
        #1;
    endtask

    task automatic tick();
        evalNeg();
        clockModel();
    endtask

    task automatic idleInputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_halt = 1'b0;
        branch_taken = 1'b0; ex_memtoreg = 1'b0;
        dbg_pause = 1'b0; dbg_step = 1'b0;
    endtask

    task automatic doReset();
        idleInputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        string      name;
        logic       memtoreg;
        logic [4:0] exRt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesRs;
        logic       usesRt;
        logic       branch;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int c0;
        int enCount;

        vecs[0] = '{"lu_rs",     1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 4'b0001};
        vecs[1] = '{"rt_zero",   1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 4'b1100};
        vecs[2] = '{"branch",    1'b0, 5'd8, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 4'b1110};
        vecs[3] = '{"branch_lu", 1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 4'b0001};
        vecs[4] = '{"lu_rt",     1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b1, 1'b0, 4'b0001};
        vecs[5] = '{"rs_unused", 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 4'b1100};
        vecs[6] = '{"no_load",   1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 4'b1100};
        vecs[7] = '{"mismatch",  1'b1, 5'd8, 5'd7, 5'd9, 1'b1, 1'b1, 1'b0, 4'b1100};

        idleInputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) modelReset(k);

        // Reset state
        doReset();
        check("reset pipe_en run",   64'(pe[0]), 64'd1);
        check("reset pipe_en pause", 64'(pe[2]), 64'd0);
        check("reset halted",        64'(hl[0]), 64'd0);
        check("reset cycle_count",   64'(cc0),   64'd0);
        check("reset stall_count",   64'(sc0),   64'd0);

        // Hazard/branch vector table in RUN
        doReset();
        for (int i = 0; i < 8; i++) begin
            ex_memtoreg  = vecs[i].memtoreg;
            ex_rt        = vecs[i].exRt;
            id_rs        = vecs[i].rs;
            id_rt        = vecs[i].rt;
            id_uses_rs   = vecs[i].usesRs;
            id_uses_rt   = vecs[i].usesRt;
            branch_taken = vecs[i].branch;
            evalNeg();
            check({vecs[i].name, " pc_write"},   64'(pw[0]), 64'(vecs[i].exp[3]));
            check({vecs[i].name, " ifid_write"}, 64'(iw[0]), 64'(vecs[i].exp[2]));
            check({vecs[i].name, " ifid_flush"}, 64'(fl[0]), 64'(vecs[i].exp[1]));
            check({vecs[i].name, " idex_clear"}, 64'(cl[0]), 64'(vecs[i].exp[0]));
            clockModel();
            if (i == 0) check("first stall_count", 64'(sc0), 64'd1);
        end
        check("table stall_count", 64'(sc0), 64'd3);
        check("table cycle_count", 64'(cc0), 64'd8);

        // HALT drain: DRAIN for three cycles, then HALTED until reset
        doReset();
        id_halt = 1'b1;
        evalNeg();
        check("halt pc_write",   64'(pw[0]), 64'd0);
        check("halt ifid_flush", 64'(fl[0]), 64'd1);
        check("halt idex_clear", 64'(cl[0]), 64'd0);
        clockModel();
        id_halt = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            evalNeg();
            check($sformatf("drain%0d pipe_en", i),    64'(pe[0]), 64'd1);
            check($sformatf("drain%0d halted", i),     64'(hl[0]), 64'd0);
            check($sformatf("drain%0d idex_clear", i), 64'(cl[0]), 64'd1);
            check($sformatf("drain%0d pc_write", i),   64'(pw[0]), 64'd0);
            clockModel();
        end
        evalNeg();
        check("halted set",     64'(hl[0]), 64'd1);
        check("halted pipe_en", 64'(pe[0]), 64'd0);
        clockModel();
        dbg_pause = 1'b1; dbg_step = 1'b1; id_halt = 1'b1; branch_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            evalNeg();
            check("halted sticky", 64'(hl[0]), 64'd1);
            clockModel();
        end
        idleInputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("post-halt reset pipe_en",     64'(pe[0]), 64'd1);
        check("post-halt reset halted",      64'(hl[0]), 64'd0);
        check("post-halt reset cycle_count", 64'(cc0),   64'd0);

        // Debug pause and single-step
        doReset();
        dbg_pause = 1'b1;
        evalNeg();
        check("pause same-cycle pipe_en", 64'(pe[0]), 64'd1);
        clockModel();
        evalNeg();
        check("paused pipe_en", 64'(pe[0]), 64'd0);
        clockModel();
        c0 = int'(cc0);
        enCount = 0;
        for (int p = 0; p < 3; p++) begin
            dbg_step = 1'b1;
            evalNeg(); enCount += int'(pe[0]); clockModel();
            dbg_step = 1'b0;
            evalNeg(); enCount += int'(pe[0]); clockModel();
            evalNeg(); enCount += int'(pe[0]); clockModel();
        end
        check("step enabled cycles", 64'(enCount), 64'd3);
        check("step cycle_count",    64'(cc0),     64'(c0 + 3));
        dbg_pause = 1'b0;
        tick();
        evalNeg();
        check("resume pipe_en", 64'(pe[0]), 64'd1);
        clockModel();

        // Counter saturation on the 4-bit instance
        doReset();
        repeat (20) tick();
        check("sat cycle_count 4b",  64'(cc1), 64'd15);
        check("wide cycle_count",    64'(cc0), 64'd20);
        tick();
        check("sat cycle_count hold", 64'(cc1), 64'd15);

        // Reset during the second drain cycle
        doReset();
        id_halt = 1'b1;
        tick();
        id_halt = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid-drain reset pipe_en",     64'(pe[0]), 64'd1);
        check("mid-drain reset halted",      64'(hl[0]), 64'd0);
        check("mid-drain reset cycle_count", 64'(cc0),   64'd0);
        check("mid-drain reset stall_count", 64'(sc0),   64'd0);
        check("mid-drain reset paused inst", 64'(pe[2]), 64'd0);

        // Randomised traffic against the model
        doReset();
        for (int n = 0; n < 1500; n++) begin
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            ex_rt        = 5'($urandom_range(0, 3));
            id_uses_rs   = 1'($urandom_range(0, 1));
            id_uses_rt   = 1'($urandom_range(0, 1));
            ex_memtoreg  = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 3) == 0);
            id_halt      = ($urandom_range(0, 24) == 0);
            dbg_step     = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) dbg_pause = ~dbg_pause;
            reset        = ($urandom_range(0, 119) == 0);
            tick();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
